// File: rtl/wallace_pkg.sv
// Shared types and defaults for the Wallace-multiplier arbiter slice.
// Holds the requester tag type (sized for the maximum of 8 requesters), the
// tag-pipe slot struct, the parameter defaults and a one-hot to tag helper.
package wallace_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned MANT_W_DEF  = 24;
    localparam int unsigned MUL_LAT_DEF = 3;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned TAG_W       = $clog2(MAX_REQ);

    typedef logic [TAG_W-1:0] req_tag_t;

    // One stage of the requester-tag shift register that tracks the multiplier
    typedef struct packed {
        logic     vld;
        req_tag_t tag;
    } tag_slot_t;

    // Index of the set bit of a one-hot vector (zero when the vector is empty)
    function automatic req_tag_t oh_to_tag(input logic [MAX_REQ-1:0] oh);
        req_tag_t tag;
        tag = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                tag = TAG_W'(i);
            end
        end
        return tag;
    endfunction

endpackage

// File: rtl/wallace_mul_arbiter_if.sv
// Bus bundle for wallace_mul_arbiter.
// Requester side : i_req_valid/i_req_a/i_req_b in, o_req_ready out,
//                  o_rsp_valid/o_rsp_p out, i_rsp_ready in.
// Multiplier side: o_mul_valid/o_mul_a/o_mul_b out, i_mul_p in.
// Status         : o_inflight, o_idle.
// slave modport is used by the arbiter, master by whatever drives it.
interface wallace_mul_arbiter_if
    import wallace_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned MANT_W  = MANT_W_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
);

    localparam int unsigned INF_W = $clog2(MUL_LAT + 2);

    logic [NUM_REQ-1:0]                 i_req_valid;
    logic [NUM_REQ-1:0][MANT_W-1:0]     i_req_a;
    logic [NUM_REQ-1:0][MANT_W-1:0]     i_req_b;
    logic [NUM_REQ-1:0]                 o_req_ready;
    logic                               o_mul_valid;
    logic [MANT_W-1:0]                  o_mul_a;
    logic [MANT_W-1:0]                  o_mul_b;
    logic [2*MANT_W-1:0]                i_mul_p;
    logic [NUM_REQ-1:0]                 o_rsp_valid;
    logic [NUM_REQ-1:0][2*MANT_W-1:0]   o_rsp_p;
    logic [NUM_REQ-1:0]                 i_rsp_ready;
    logic [INF_W-1:0]                   o_inflight;
    logic                               o_idle;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_mul_p, i_rsp_ready,
        output o_req_ready, o_mul_valid, o_mul_a, o_mul_b,
               o_rsp_valid, o_rsp_p, o_inflight, o_idle
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_mul_p, i_rsp_ready,
        input  o_req_ready, o_mul_valid, o_mul_a, o_mul_b,
               o_rsp_valid, o_rsp_p, o_inflight, o_idle
    );

endinterface

// File: rtl/wallace_rr_arb.sv
// Requester arbiter for wallace_mul_arbiter.
// Ports: i_eligible (per-requester eligibility), i_ptr (round-robin start
// index), o_grant_c (combinational one-hot grant, zero if nobody eligible).
// Macro WALLACE_ARB_FIXED_PRIO_EN: lowest-index eligible wins, i_ptr removed.
module wallace_rr_arb
    import wallace_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] i_eligible,
`ifndef WALLACE_ARB_FIXED_PRIO_EN
    input  req_tag_t           i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_grant_c
);

`ifdef WALLACE_ARB_FIXED_PRIO_EN

    // Isolate the lowest set bit
    always_comb begin
        o_grant_c = i_eligible & (~i_eligible + NUM_REQ'(1));
    end

`else

    logic [NUM_REQ-1:0]   rot_c;
    logic [NUM_REQ-1:0]   pick_c;
    logic [2*NUM_REQ-1:0] back_c;

    // Rotate so i_ptr lands on bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot_c     = NUM_REQ'({i_eligible, i_eligible} >> i_ptr);
        pick_c    = rot_c & (~rot_c + NUM_REQ'(1));
        back_c    = {pick_c, pick_c} << i_ptr;
        o_grant_c = NUM_REQ'(back_c >> NUM_REQ);
    end

`endif

endmodule

// File: rtl/wallace_mul_arbiter.sv
// Shares one fixed-latency Wallace multiplier among NUM_REQ requesters.
// Ports: i_clk, i_rst (synchronous, active-high) and bus (slave modport of
// wallace_mul_arbiter_if) carrying request, multiplier and response signals.
// An accepted request is issued to the multiplier the next cycle; its tag
// rides a MUL_LAT+1 deep shift register so the product can be steered to the
// owner's response register. One outstanding op per requester.
// Macro WALLACE_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no ptr.
module wallace_mul_arbiter
    import wallace_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned MANT_W  = MANT_W_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    wallace_mul_arbiter_if.slave bus
);

    localparam int unsigned INF_W  = $clog2(MUL_LAT + 2);
    localparam int unsigned PIPE_D = MUL_LAT + 1;
    localparam int unsigned PW     = 2 * MANT_W;

    logic [NUM_REQ-1:0]          busy_q, busy_d;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][PW-1:0]  rsp_p_q, rsp_p_d;
    logic                        mul_valid_q, mul_valid_d;
    logic [MANT_W-1:0]           mul_a_q, mul_a_d;
    logic [MANT_W-1:0]           mul_b_q, mul_b_d;
    logic [INF_W-1:0]            inflight_q, inflight_d;
    logic                        idle_q, idle_d;
    tag_slot_t                   pipe_q [PIPE_D];
    tag_slot_t                   pipe_d [PIPE_D];
`ifndef WALLACE_ARB_FIXED_PRIO_EN
    req_tag_t                    ptr_q, ptr_d;
`endif

    logic [NUM_REQ-1:0]          eligible_c;
    logic [NUM_REQ-1:0]          grant_c;
    logic [NUM_REQ-1:0]          req_ready_c;
    logic                        issue_c;
    logic                        capture_c;
    req_tag_t                    issue_tag_c;

    // Arbitration among requesters with valid operands and no outstanding op
    assign eligible_c = bus.i_req_valid & ~busy_q;

    wallace_rr_arb #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .i_eligible (eligible_c),
`ifndef WALLACE_ARB_FIXED_PRIO_EN
        .i_ptr      (ptr_q),
`endif
        .o_grant_c  (grant_c)
    );

    // Grants are suppressed while reset is asserted
    assign req_ready_c = i_rst ? '0 : grant_c;

    // Next-state: issue, tag pipe, response capture/handshake, counters
    always_comb begin
        issue_c     = |req_ready_c;
        issue_tag_c = oh_to_tag(MAX_REQ'(req_ready_c));
        capture_c   = pipe_q[MUL_LAT].vld;

        busy_d      = busy_q | req_ready_c;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        mul_valid_d = issue_c;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        inflight_d  = inflight_q;
`ifndef WALLACE_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
        if (issue_c) begin
            ptr_d = (issue_tag_c == TAG_W'(NUM_REQ - 1)) ? '0 : issue_tag_c + TAG_W'(1);
        end
`endif

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (req_ready_c[k]) begin
                mul_a_d = bus.i_req_a[k];
                mul_b_d = bus.i_req_b[k];
            end
        end

        pipe_d[0].vld = issue_c;
        pipe_d[0].tag = issue_tag_c;
        for (int unsigned i = 1; i < PIPE_D; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // A requester is busy, so its capture and handshake never coincide
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (rsp_valid_q[k] && bus.i_rsp_ready[k]) begin
                busy_d[k]      = 1'b0;
                rsp_valid_d[k] = 1'b0;
            end
            if (capture_c && (pipe_q[MUL_LAT].tag == TAG_W'(k))) begin
                rsp_valid_d[k] = 1'b1;
                rsp_p_d[k]     = bus.i_mul_p;
            end
        end

        case ({issue_c, capture_c})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        idle_d = (inflight_d == '0) && (busy_d == '0);
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            inflight_q  <= '0;
            idle_q      <= 1'b1;
            for (int unsigned i = 0; i < PIPE_D; i++) begin
                pipe_q[i] <= '0;
            end
`ifndef WALLACE_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            inflight_q  <= inflight_d;
            idle_q      <= idle_d;
            pipe_q      <= pipe_d;
`ifndef WALLACE_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.o_req_ready = req_ready_c;
    assign bus.o_mul_valid = mul_valid_q;
    assign bus.o_mul_a     = mul_a_q;
    assign bus.o_mul_b     = mul_b_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_p     = rsp_p_q;
    assign bus.o_inflight  = inflight_q;
    assign bus.o_idle      = idle_q;

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Bench for wallace_mul_arbiter (NUM_REQ=4, MANT_W=24, MUL_LAT=3).
// A transaction-level model (per-requester outstanding op with its accept
// cycle and operands) predicts every output each cycle; directed scenarios
// add hand-computed literal expectations.
module tb_wallace_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int L  = 3;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wallace_mul_arbiter_if #(.NUM_REQ(N), .MANT_W(W), .MUL_LAT(L)) bus ();

    wallace_mul_arbiter #(.NUM_REQ(N), .MANT_W(W), .MUL_LAT(L)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Behavioural multiplier: product of issued operands appears L cycles
    // after o_mul_valid; junk is presented on idle slots.
    logic [PW-1:0] mp [L];
    always @(posedge clk) begin
        mp[0] <= bus.o_mul_valid ? PW'(bus.o_mul_a) * PW'(bus.o_mul_b)
                                 : PW'({$urandom, $urandom});
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign bus.i_mul_p = mp[L-1];

    int checks = 0;
    int errors = 0;

    // Transaction model state
    bit            m_busy [N];
    int            m_iss  [N];
    logic [W-1:0]  m_a    [N];
    logic [W-1:0]  m_b    [N];
    int            m_ptr  = 0;
    bit            m_mulv = 1'b0;
    logic [W-1:0]  m_la   = '0;
    logic [W-1:0]  m_lb   = '0;
    int            cyc    = 0;
    int            last_g = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One clock cycle: compare at negedge, advance model at posedge
    task automatic tick();
        int           g;
        int           infl;
        bit           any_busy;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
`ifdef WALLACE_ARB_FIXED_PRIO_EN
                int k = i;
`else
                int k = (m_ptr + i) % N;
`endif
                if (g < 0 && bus.i_req_valid[k] && !m_busy[k]) g = k;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        erv = '0;
        infl = 0;
        any_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (m_busy[k]) begin
                any_busy = 1'b1;
                if (cyc >= m_iss[k] + 2 + L) erv[k] = 1'b1;
                if (cyc >= m_iss[k] + 1 && cyc <= m_iss[k] + 1 + L) infl++;
            end
        end
        chk("req_ready", bus.o_req_ready, eg);
        chk("mul_valid", bus.o_mul_valid, m_mulv);
        chk("mul_a", bus.o_mul_a, m_la);
        chk("mul_b", bus.o_mul_b, m_lb);
        chk("rsp_valid", bus.o_rsp_valid, erv);
        for (int k = 0; k < N; k++) begin
            if (erv[k]) chk($sformatf("rsp_p%0d", k), bus.o_rsp_p[k], PW'(m_a[k]) * PW'(m_b[k]));
        end
        chk("inflight", bus.o_inflight, infl);
        chk("idle", bus.o_idle, (infl == 0) && !any_busy);
        last_g = g;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
            m_ptr  = 0;
            m_mulv = 1'b0;
            m_la   = '0;
            m_lb   = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (erv[k] && bus.i_rsp_ready[k]) m_busy[k] = 1'b0;
            end
            m_mulv = (g >= 0);
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_iss[g]  = cyc;
                m_a[g]    = bus.i_req_a[g];
                m_b[g]    = bus.i_req_b[g];
                m_la      = bus.i_req_a[g];
                m_lb      = bus.i_req_b[g];
                m_ptr     = (g + 1) % N;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int exp_seq [12] = '{0, 1, 2, 3, -1, -1, 0, 1, 2, 3, -1, -1};
        int g0;
        int g2;
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 1'b0;
            m_iss[k]  = 0;
        end
        bus.i_req_valid = '0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_rsp_ready = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        chk("rst_idle", bus.o_idle, 1);
        chk("rst_inflight", bus.o_inflight, 0);
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);

        // Single op 3*5 on requester 0
        bus.i_req_a[0]  = 24'h000003;
        bus.i_req_b[0]  = 24'h000005;
        bus.i_req_valid = 4'b0001;
        tick();
        chk("single_grant", last_g, 0);
        bus.i_req_valid = '0;
        chk("single_t1_mul_valid", bus.o_mul_valid, 1);
        chk("single_t1_mul_a", bus.o_mul_a, 24'h000003);
        repeat (3) tick();
        chk("single_t4_rsp_valid", bus.o_rsp_valid, 0);
        tick();
        chk("single_t5_rsp_valid", bus.o_rsp_valid, 4'b0001);
        chk("single_t5_rsp_p", bus.o_rsp_p[0], 48'h00000000000F);
        bus.i_rsp_ready = 4'hF;
        repeat (3) tick();
        chk("single_idle", bus.o_idle, 1);

        // Reset two cycles after an issue drops the op
        bus.i_req_a[0]  = 24'h000007;
        bus.i_req_b[0]  = 24'h000009;
        bus.i_req_valid = 4'b0001;
        tick();
        bus.i_req_valid = '0;
        tick();
        rst = 1'b1;
        bus.i_req_valid = 4'b0010;
        tick();
        rst = 1'b0;
        bus.i_req_valid = '0;
        chk("rstmid_inflight", bus.o_inflight, 0);
        chk("rstmid_idle", bus.o_idle, 1);
        chk("rstmid_rsp_valid", bus.o_rsp_valid, 0);
        repeat (6) tick();
        chk("rstmid_no_rsp", bus.o_rsp_valid, 0);

        // All requesters valid, responses always accepted
        for (int k = 0; k < N; k++) begin
            bus.i_req_a[k] = 24'h000100 + W'(k);
            bus.i_req_b[k] = 24'h000010 + W'(k);
        end
        bus.i_req_valid = 4'hF;
        bus.i_rsp_ready = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("rr_grant%0d", i), last_g, exp_seq[i]);
        end

        // Requester 2 backpressured for 20 cycles
        bus.i_rsp_ready = 4'b1011;
        g0 = 0;
        g2 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_g == 0) g0++;
            if (last_g == 2) g2++;
        end
        chk("bp_req2_grants", g2, 0);
        chk("bp_req0_progress", (g0 >= 2), 1);
        chk("bp_rsp_valid2", bus.o_rsp_valid[2], 1);
        chk("bp_rsp_p2", bus.o_rsp_p[2], 48'h000000001224);
        bus.i_req_valid = '0;
        bus.i_rsp_ready = 4'hF;
        repeat (10) tick();
        chk("bp_drain_idle", bus.o_idle, 1);

        // Maximum operands on requester 3
        bus.i_req_a[3]  = 24'hFFFFFF;
        bus.i_req_b[3]  = 24'hFFFFFF;
        bus.i_req_valid = 4'b1000;
        bus.i_rsp_ready = '0;
        tick();
        chk("max_grant", last_g, 3);
        bus.i_req_valid = '0;
        repeat (4) tick();
        chk("max_rsp_valid", bus.o_rsp_valid, 4'b1000);
        chk("max_rsp_p", bus.o_rsp_p[3], 48'hFFFFFE000001);
        bus.i_rsp_ready = 4'hF;
        repeat (2) tick();
        chk("max_idle", bus.o_idle, 1);

`ifdef WALLACE_ARB_FIXED_PRIO_EN
        // Lowest index wins under fixed priority
        bus.i_req_valid = 4'b1010;
        tick();
        chk("fixed_first", last_g, 1);
        bus.i_req_valid = '0;
        repeat (8) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wallace_mul_arbiter.md
WALLACE_MUL_ARBITER -- requirements
Module: wallace_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter MANT_W, default 24, unsigned operand width.
REQ-003 SHALL have parameter MUL_LAT, default 3, fixed pipeline latency of the Wallace multiplier, in cycles (1..8).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  NUM_REQ  request valid, one per requester
- i_req_a, i_req_b  in  NUM_REQ x MANT_W  operands per requester
- o_req_ready  out  NUM_REQ  grant (one-hot or zero)
- o_mul_valid  out  1  operands valid to multiplier
- o_mul_a, o_mul_b  out  MANT_W  operands to multiplier
- i_mul_p  in  2*MANT_W  product from multiplier
- o_rsp_valid  out  NUM_REQ  response valid per requester
- o_rsp_p  out  NUM_REQ x 2*MANT_W  response product per requester
- i_rsp_ready  in  NUM_REQ  response accept per requester
- o_inflight  out  $clog2(MUL_LAT+2)  ops issued, product not yet captured
- o_idle  out  1  no in-flight op and no pending response

Function
REQ-005 SHALL treat requester k as eligible iff i_req_valid[k]=1 and busy[k]=0.
REQ-006 SHALL assert at most one o_req_ready bit per cycle, only to an eligible requester; o_req_ready is combinational from i_req_valid and registered state.
REQ-007 SHALL arbitrate round-robin: search starts at ptr, wraps from NUM_REQ-1 to 0; after a grant to k, ptr <= (k+1) mod NUM_REQ; ptr unchanged when no grant.
REQ-008 SHALL, on accept at cycle t (valid & ready), set busy[k] and drive o_mul_valid=1, o_mul_a/b = captured operands, at t+1 for exactly one cycle.
REQ-009 SHALL carry requester index through an internal valid/tag shift register of depth MUL_LAT+1; product present on i_mul_p at t+1+MUL_LAT is captured into the tagged requester's response register.
REQ-010 SHALL assert o_rsp_valid[k] from t+2+MUL_LAT, holding o_rsp_p[k] stable until i_rsp_ready[k]=1.
REQ-011 SHALL clear busy[k] and o_rsp_valid[k] at the edge where o_rsp_valid[k] & i_rsp_ready[k]; requester k is eligible from the following cycle.
REQ-012 SHALL sustain one issue per cycle across distinct requesters; at most one outstanding op per requester.
REQ-013 SHALL hold o_mul_a/b at last value when o_mul_valid=0.
REQ-014 SHALL update o_inflight: +1 on issue, -1 on capture, unchanged on both or neither; never exceeds MUL_LAT+1.
REQ-015 SHALL drive o_idle=1 iff o_inflight=0 and all busy bits zero.
REQ-016 SHALL ignore i_mul_p when the tag pipe slot is invalid.

Reset
REQ-017 SHALL, on i_rst=1, clear ptr, busy, tag pipe, o_inflight, o_rsp_valid, o_mul_valid, o_mul_a/b, o_rsp_p to 0; o_req_ready=0 during reset.
REQ-018 SHALL discard products of ops in flight at reset; no response is produced for them.

Configuration
REQ-019 SHALL, with WALLACE_ARB_FIXED_PRIO_EN defined, grant the lowest-index eligible requester and omit ptr; without it, round-robin per REQ-007.

Structure
REQ-020 SHALL place requester tag typedef, NUM_REQ default and MUL_LAT default in shared package wallace_pkg.
REQ-021 SHALL implement arbitration in one sub-module wallace_rr_arb (eligible vector + ptr in, one-hot grant out).

Verification (MANT_W=24, MUL_LAT=3, NUM_REQ=4)
REQ-022 Single op: req0 a=0x000003, b=0x000005 at t -> o_mul_valid at t+1, o_rsp_valid[0] at t+5 with p=0x00000000000F.
REQ-023 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3 on consecutive cycles, then 0 again once busy[0] clears; no requester starved.
REQ-024 Backpressure: i_rsp_ready[2]=0 for 20 cycles -> requester 2 not regranted, o_rsp_p[2] stable, others proceed.
REQ-025 Max operands 0xFFFFFF x 0xFFFFFF -> p=0xFFFFFE000001 on correct requester.
REQ-026 i_rst pulsed 2 cycles after issue -> no o_rsp_valid, o_inflight=0, o_idle=1 next cycle.
REQ-027 WALLACE_ARB_FIXED_PRIO_EN defined, req1 and req3 valid -> req1 granted first.
